sr_latch_ctrl: RTL and testbench

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

---
 rtl/sr_latch_ctrl.sv | 140 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// Arbitrated set/reset pulse controller for an external SR latch.
// Round-robin grant, fixed-width drive pulse, then a q_fb completion check.
module sr_latch_ctrl #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  input  logic             q_fb,
  output logic             latch_set,
  output logic             latch_reset,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             err,
  output logic [2:0]       err_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(PULSE_CYC - 1);
  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

  state_e     state_q, state_d;
  logic       op_q, op_d;            // 1 = drive q to 1, 0 = drive q to 0
  logic [2:0] idx_q, idx_d;
  logic [2:0] rr_q, rr_d;
  logic [2:0] err_id_q, err_id_d;
  logic [3:0] cnt_q, cnt_d;

  logic [7:0] set8, elig8, ill8, ack8;
  logic       gnt_found, ill_found, err_c;
  logic [2:0] gnt_idx, ill_idx, err_now;

  assign set8  = 8'(set_req);
  assign elig8 = 8'(set_req ^ clr_req);
  assign ill8  = 8'(set_req & clr_req);

  // Round-robin search starting at rr_q, wrapping at N_REQ.
  always_comb begin
    int unsigned j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_found && elig8[3'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(j);
      end
    end
  end

  always_comb begin
    ill_found = 1'b0;
    ill_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!ill_found && ill8[3'(k)]) begin
        ill_found = 1'b1;
        ill_idx   = 3'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    err_id_d = err_id_q;
    ack8     = '0;
    err_c    = 1'b0;
    err_now  = err_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = PULSE;
          idx_d   = gnt_idx;
          op_d    = set8[gnt_idx];
          cnt_d   = CNT_LOAD;
          rr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 3'd1;
        end else if (ill_found) begin
          err_c    = 1'b1;
          err_now  = ill_idx;
          err_id_d = ill_idx;
        end
      end
      PULSE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        state_d = IDLE;
        if (q_fb == op_q) begin
          ack8[idx_q] = 1'b1;
        end else begin
          err_c    = 1'b1;
          err_now  = idx_q;
          err_id_d = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      idx_q    <= '0;
      rr_q     <= '0;
      err_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      err_id_q <= err_id_d;
      cnt_q    <= cnt_d;
    end
  end

  // Drives depend only on registered state, so they can never overlap.
  assign latch_set   = (state_q == PULSE) &&  op_q;
  assign latch_reset = (state_q == PULSE) && !op_q;
  assign busy        = (state_q != IDLE);
  // Completion pulses are suppressed in a cycle whose closing edge resets.
  assign ack         = reset ? '0 : ack8[N_REQ-1:0];
  assign err         = err_c && !reset;
  assign err_id      = err ? err_now : err_id_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sr_latch_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned P = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] set_req = '0;
  logic [N-1:0] clr_req = '0;
  logic         q_fb;
  logic         latch_set, latch_reset, busy, err;
  logic [N-1:0] ack;
  logic [2:0]   err_id;

  logic q_lat = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  logic drop_on_ack = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;
  int ack_idx_q[$];
  int ack_cyc_q[$];

  logic         s_ls, s_lr, s_busy, s_err;
  logic [N-1:0] s_ack;
  logic [2:0]   s_eid;

  sr_latch_ctrl #(.N_REQ(N), .PULSE_CYC(P)) dut (
    .clk(clk), .reset(reset), .set_req(set_req), .clr_req(clr_req),
    .q_fb(q_fb), .latch_set(latch_set), .latch_reset(latch_reset),
    .ack(ack), .busy(busy), .err(err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  // Behavioural latch being driven; q_fb can be forced to emulate a fault.
  always @(posedge clk) begin
    if (latch_set)        q_lat <= 1'b1;
    else if (latch_reset) q_lat <= 1'b0;
  end
  assign q_fb = force_en ? force_val : q_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int unsigned a;
    int r;
    a = 32'(v);
    r = -1;
    for (int i = 0; i < N; i++) if (((a >> i) & 1) != 0) r = i;
    return r;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // Reference model: an operation is "active" for P drive cycles followed by
  // one check cycle; phase counts cycles since the grant.
  bit m_active = 0;
  int m_phase = 0;
  bit m_op = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_errid = 0;

  initial begin
    @(posedge clk);
    forever begin
      int unsigned sr, cr;
      bit found, ill_found, e_ls, e_lr, e_busy, e_err;
      int gi, ii, e_eid, j;
      int unsigned e_ack;
      @(negedge clk);
      sr = 32'(set_req);
      cr = 32'(clr_req);
      found = 0; ill_found = 0; gi = 0; ii = 0;
      e_ls = 0; e_lr = 0; e_busy = 0; e_err = 0; e_ack = 0; e_eid = m_errid;
      if (!m_active) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && ((((sr ^ cr) >> j) & 1) != 0)) begin found = 1; gi = j; end
        end
        for (int k = 0; k < N; k++)
          if (!ill_found && ((((sr & cr) >> k) & 1) != 0)) begin ill_found = 1; ii = k; end
        if (!found && ill_found && !reset) begin e_err = 1; e_eid = ii; end
      end else begin
        e_busy = 1;
        if (m_phase <= P) begin
          e_ls = m_op; e_lr = !m_op;
        end else if (!reset) begin
          if (q_fb == m_op) e_ack = 32'd1 << m_idx;
          else begin e_err = 1; e_eid = m_idx; end
        end
      end
      chk("latch_set", 32'(latch_set), 32'(e_ls));
      chk("latch_reset", 32'(latch_reset), 32'(e_lr));
      chk("no_overlap", 32'(latch_set & latch_reset), 32'd0);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ack", 32'(ack), e_ack);
      chk("err", 32'(err), 32'(e_err));
      chk("err_id", 32'(err_id), 32'(e_eid));
      if (reset) begin
        m_active = 0; m_ptr = 0; m_errid = 0;
      end else begin
        if (e_err) m_errid = e_eid;
        if (!m_active) begin
          if (found) begin
            m_active = 1; m_phase = 1; m_idx = gi;
            m_op = (((sr >> gi) & 1) != 0);
            m_ptr = (gi + 1) % N;
          end
        end else if (m_phase == P + 1) begin
          m_active = 0;
        end else begin
          m_phase++;
        end
      end
    end
  end

  // One clock: snapshot outputs mid-cycle, then advance past the next edge.
  task automatic step();
    @(negedge clk);
    s_ls = latch_set; s_lr = latch_reset; s_busy = busy;
    s_err = err; s_eid = err_id; s_ack = ack;
    if (ack != '0) begin
      ack_idx_q.push_back(oh_idx(ack));
      ack_cyc_q.push_back(cyc - base);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (drop_on_ack) begin
      set_req = set_req & ~s_ack;
      clr_req = clr_req & ~s_ack;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; set_req = '0; clr_req = '0;
    repeat (n) step();
    reset = 1'b0;
    ack_idx_q.delete(); ack_cyc_q.delete();
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and single set operation.
    do_reset(2);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_ls", 32'(s_ls), 32'd0);
    chk("rst_lr", 32'(s_lr), 32'd0);
    chk("rst_err_id", 32'(s_eid), 32'd0);
    drop_on_ack = 1'b1;
    set_req = 4'b0001;
    step(); chk("A_c0_busy", 32'(s_busy), 32'd0);
    step(); chk("A_c1_ls", 32'(s_ls), 32'd1);
    step(); chk("A_c2_ls", 32'(s_ls), 32'd1);
    step(); chk("A_c3_ack", 32'(s_ack), 32'h1);
            chk("A_c3_ls", 32'(s_ls), 32'd0);
    step(); chk("A_c4_busy", 32'(s_busy), 32'd0);

    // Simultaneous set on 0 and clear on 1.
    do_reset(1);
    set_req = 4'b0001; clr_req = 4'b0010;
    repeat (12) step();
    chk("B_nacks", 32'(ack_idx_q.size()), 32'd2);
    chk("B_first", 32'(qget(ack_idx_q, 0)), 32'd0);
    chk("B_second", 32'(qget(ack_idx_q, 1)), 32'd1);
    chk("B_first_cyc", 32'(qget(ack_cyc_q, 0)), 32'd3);
    chk("B_gap", 32'(qget(ack_cyc_q, 1) - qget(ack_cyc_q, 0)), 32'd4);

    // All requesters held continuously: rotation with P+2 spacing.
    do_reset(1);
    drop_on_ack = 1'b0;
    set_req = 4'b1111;
    repeat (22) step();
    chk("C_nacks", 32'(ack_idx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("C_order", 32'(qget(ack_idx_q, i)), 32'(i % 4));
      chk("C_time", 32'(qget(ack_cyc_q, i)), 32'(3 + 4 * i));
    end

    // Illegal requester 2.
    do_reset(1);
    set_req = 4'b0100; clr_req = 4'b0100;
    step(); chk("D_err0", 32'(s_err), 32'd1);
            chk("D_id0", 32'(s_eid), 32'd2);
            chk("D_busy", 32'(s_busy), 32'd0);
    step(); chk("D_err1", 32'(s_err), 32'd1);
            chk("D_ls", 32'(s_ls | s_lr), 32'd0);
            chk("D_ack", 32'(s_ack), 32'd0);
    set_req = '0; clr_req = '0;
    step(); chk("D_err_off", 32'(s_err), 32'd0);
            chk("D_id_hold", 32'(s_eid), 32'd2);

    // Clear with q_fb stuck at 1.
    do_reset(1);
    drop_on_ack = 1'b1;
    force_en = 1'b1; force_val = 1'b1;
    clr_req = 4'b0001;
    step();
    step(); chk("E_c1_lr", 32'(s_lr), 32'd1);
    step(); chk("E_c2_lr", 32'(s_lr), 32'd1);
    step(); chk("E_c3_err", 32'(s_err), 32'd1);
            chk("E_c3_id", 32'(s_eid), 32'd0);
            chk("E_c3_ack", 32'(s_ack), 32'd0);
    clr_req = '0;
    step(); chk("E_c4_busy", 32'(s_busy), 32'd0);
    force_en = 1'b0;

    // Reset during the second pulse cycle, then pointer restarts at 0.
    do_reset(1);
    set_req = 4'b0001;
    step();
    step(); chk("F_c1_ls", 32'(s_ls), 32'd1);
    reset = 1'b1; set_req = '0;
    step(); chk("F_c2_ack", 32'(s_ack), 32'd0);
            chk("F_c2_err", 32'(s_err), 32'd0);
    reset = 1'b0;
    set_req = 4'b0011;
    ack_idx_q.delete(); ack_cyc_q.delete(); base = cyc;
    step(); chk("F_c3_drive", 32'(s_ls | s_lr), 32'd0);
            chk("F_c3_busy", 32'(s_busy), 32'd0);
    repeat (10) step();
    chk("F_first", 32'(qget(ack_idx_q, 0)), 32'd0);
    chk("F_second", 32'(qget(ack_idx_q, 1)), 32'd1);

    do_reset(1);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
